// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-TX state encoding, error codes, command bytes
// and the small helpers used by the transmitter and line conditioning.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_ERR
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       parity;
    } ps2_frame_t;

    localparam logic [1:0] PS2_ERR_NONE = 2'b00;
    localparam logic [1:0] PS2_ERR_REQ  = 2'b01;
    localparam logic [1:0] PS2_ERR_XFER = 2'b10;
    localparam logic [1:0] PS2_ERR_NACK = 2'b11;

    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

    function automatic logic ps2_odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    function automatic int ps2_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Conditions one raw open-drain PS/2 line: 2-FF synchronizer, a glitch filter
// that needs FILTER_LEN agreeing samples, and a 1->0 strobe on the filtered level.
module ps2_line_sync #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic line_raw,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_pipe;
    logic [CW-1:0] diff_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_pipe <= 2'b11;
            diff_cnt  <= '0;
            level     <= 1'b1;
            fall      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], line_raw};
            fall      <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (sync_pipe[1] == level) begin
                diff_cnt <= '0;
            end else if (diff_cnt == CW'(FILTER_LEN - 1)) begin
                level    <= sync_pipe[1];
                diff_cnt <= '0;
                fall     <= level;
            end else begin
                diff_cnt <= diff_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11 device
// clocked bits with device ACK, then wait for bus idle; reports done or error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int REQ_TIMEOUT    = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);
    localparam int TW = ps2_max3($clog2(INHIBIT_CYCLES + 1), $clog2(REQ_TIMEOUT + 1),
                                 $clog2(XFER_TIMEOUT + 1));
    typedef logic [TW-1:0] tmr_t;
    localparam tmr_t TMR_INH = tmr_t'(INHIBIT_CYCLES - 1);
    localparam tmr_t TMR_REQ = tmr_t'(REQ_TIMEOUT);
    localparam tmr_t TMR_XFR = tmr_t'(XFER_TIMEOUT);

    ps2_state_e state, state_nxt;
    ps2_frame_t frame;
    logic [3:0] edge_cnt;
    tmr_t       tmr;
    logic       tmr_zero;
    logic       data_oe_q;
    logic       clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk(clk), .reset(reset), .line_raw(ps2_clk_in), .level(clk_lvl), .fall(clk_fall)
    );
    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
        .clk(clk), .reset(reset), .line_raw(ps2_data_in), .level(dat_lvl), .fall(dat_fall_unused)
    );

    assign tmr_zero    = (tmr == '0);
    assign ps2_data_oe = data_oe_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:      if (tx_valid) state_nxt = ST_INHIBIT;
            ST_INHIBIT:   if (tmr_zero) state_nxt = ST_RTS;
            ST_RTS:       state_nxt = ST_XFER;
            ST_XFER: begin
                if (clk_fall) begin
                    if (edge_cnt == 4'd10) state_nxt = dat_lvl ? ST_ERR : ST_WAIT_IDLE;
                end else if (tmr_zero) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) state_nxt = ST_IDLE;
                else if (tmr_zero)      state_nxt = ST_ERR;
            end
            ST_ERR:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready   = 1'b0;
        ps2_clk_oe = 1'b0;
        rx_inhibit = 1'b1;
        tx_done    = 1'b0;
        tx_err     = 1'b0;
        unique case (state)
            ST_IDLE:              begin tx_ready = 1'b1; rx_inhibit = 1'b0; end
            ST_INHIBIT, ST_RTS:   ps2_clk_oe = 1'b1;
            ST_WAIT_IDLE:         tx_done = clk_lvl && dat_lvl;
            ST_ERR:               tx_err = 1'b1;
            default:              ;
        endcase
    end

    // One saturating timer is reloaded for whichever phase is being bounded.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame     <= '0;
            edge_cnt  <= '0;
            tmr       <= '0;
            data_oe_q <= 1'b0;
            err_code  <= PS2_ERR_NONE;
        end else begin
            if (!tmr_zero) tmr <= tmr - 1'b1;
            unique case (state)
                ST_IDLE: begin
                    data_oe_q <= 1'b0;
                    if (tx_valid) begin
                        frame    <= {tx_data, ps2_odd_parity(tx_data)};
                        edge_cnt <= '0;
                        tmr      <= TMR_INH;
                        err_code <= PS2_ERR_NONE;
                    end
                end
                ST_INHIBIT: if (tmr_zero) data_oe_q <= 1'b1;
                ST_RTS:     tmr <= TMR_REQ;
                ST_XFER: begin
                    if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt == 4'd0)      tmr <= TMR_XFR;
                        if (edge_cnt < 4'd8)       data_oe_q <= ~frame.data[edge_cnt[2:0]];
                        else if (edge_cnt == 4'd8) data_oe_q <= ~frame.parity;
                        else                       data_oe_q <= 1'b0;
                        if (edge_cnt == 4'd10) begin
                            if (dat_lvl) err_code <= PS2_ERR_NACK;
                            else         tmr <= TMR_XFR;
                        end
                    end else if (tmr_zero) begin
                        err_code  <= (edge_cnt == 4'd0) ? PS2_ERR_REQ : PS2_ERR_XFER;
                        data_oe_q <= 1'b0;
                    end
                end
                ST_WAIT_IDLE: if (!(clk_lvl && dat_lvl) && tmr_zero) err_code <= PS2_ERR_XFER;
                ST_ERR:       data_oe_q <= 1'b0;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural PS/2 device, a table
// of command scenarios, randomized sends and hand-written reset/extra-edge cases.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 60;
    localparam int REQ = 300;
    localparam int XFR = 2000;
    localparam int FLT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       rx_inhibit, tx_done, tx_err;
    logic [1:0] err_code;
    logic       dev_clk, dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .REQ_TIMEOUT(REQ), .XFER_TIMEOUT(XFR), .FILTER_LEN(FLT)
    ) dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .rx_inhibit(rx_inhibit), .tx_done(tx_done), .tx_err(tx_err),
        .err_code(err_code)
    );

    // Wired-AND open-drain lines: host and device each can only pull low.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_dat & ~ps2_data_oe;

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0, n_fail = 0;
    int done_cnt = 0, err_cnt = 0, err_cyc = 0;
    logic [1:0] prev_code = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (tx_done || tx_err)) check("done_err_exclusive", tx_done & tx_err, 0);
        if (!reset && tx_done) done_cnt++;
        if (!reset && tx_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    function automatic bit model_parity(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // Accept a byte, check inhibit length and RTS, return the clock-release cycle.
    task automatic start_tx(input logic [7:0] b, input bit hold_valid, output int rel_cyc);
        int w;
        @(negedge clk);
        check("err_code_hold", err_code, prev_code);
        check("ready_idle", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_data = 8'($urandom);
        check("accept_clk_oe", ps2_clk_oe, 1);
        check("busy_ready", tx_ready, 0);
        check("busy_rx_inhibit", rx_inhibit, 1);
        w = 0;
        while (!ps2_data_oe && w < INH + 20) begin
            w++;
            @(negedge clk);
        end
        check_range("inhibit_len", w, INH, INH + 1);
        check("rts_clk_low", ps2_clk_oe, 1);
        w = 0;
        while (ps2_clk_oe && w < 10) begin
            w++;
            @(negedge clk);
        end
        check("start_bit_held", ps2_data_oe, 1);
        rel_cyc = cyc;
        if (hold_valid) tx_data = b;
        else tx_valid = 1'b0;
    endtask

    // Device clocks `edges` bits (max 10 sampled), then an ACK edge if edges >= 11.
    task automatic dev_clock(input int edges, input bit ack, output logic [9:0] smp,
                             output int first_fall);
        smp = '1;
        first_fall = 0;
        for (int k = 1; k <= edges && k <= 10; k++) begin
            dev_clk = 1'b0;
            if (k == 1) first_fall = cyc;
            repeat (20) @(negedge clk);
            smp[k-1] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
        end
        if (edges >= 11) begin
            if (ack) dev_dat = 1'b0;
            repeat (10) @(negedge clk);
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
            dev_clk = 1'b1;
            repeat (10) @(negedge clk);
            dev_dat = 1'b1;
        end
    endtask

    task automatic run_vec(input logic [7:0] cmd, input int edges, input bit ack,
                           input bit exp_par, input bit exp_done, input logic [1:0] exp_code);
        int rel, ff, w, d0, e0;
        logic [9:0] smp;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(cmd, 1'b0, rel);
        repeat (30) @(negedge clk);
        dev_clock(edges, ack, smp, ff);
        w = 0;
        while (done_cnt == d0 && err_cnt == e0 && w < REQ + XFR + 100) begin
            w++;
            @(negedge clk);
        end
        check("outcome_seen", (done_cnt != d0) || (err_cnt != e0), 1);
        if (edges >= 10) begin
            check("data_bits", smp[7:0], cmd);
            check("parity_bit", smp[8], exp_par);
            check("stop_bit", smp[9], 1);
        end
        if (edges == 0) check_range("req_timeout", err_cyc - rel, REQ - 1, REQ + 3);
        else if (edges < 11) check_range("xfer_timeout", err_cyc - ff, XFR, XFR + 12);
        check("done_pulses", done_cnt - d0, exp_done);
        check("err_pulses", err_cnt - e0, !exp_done);
        check("err_code", err_code, exp_code);
        @(negedge clk);
        check("ready_after", tx_ready, 1);
        check("clk_released", ps2_clk_oe, 0);
        check("data_released", ps2_data_oe, 0);
        check("rx_inhibit_after", rx_inhibit, 0);
        prev_code = exp_code;
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         edges;
        bit         ack;
        bit         exp_par;
        bit         exp_done;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int rel, ff, d0, e0;
        logic [9:0] smp;
        logic [7:0] b;
        bit ack;

        vecs[0] = '{8'hED, 11, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[1] = '{8'hF4, 11, 1'b1, 1'b0, 1'b1, 2'b00};
        vecs[2] = '{8'h00,  0, 1'b1, 1'b1, 1'b0, 2'b01};
        vecs[3] = '{8'hF5,  5, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[4] = '{8'hED, 11, 1'b0, 1'b1, 1'b0, 2'b11};
        vecs[5] = '{8'hFF, 11, 1'b1, 1'b1, 1'b1, 2'b00};
        vecs[6] = '{8'hFA, 11, 1'b1, 1'b1, 1'b1, 2'b00};

        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_dat = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_rx_inhibit", rx_inhibit, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_err_code", err_code, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec(vecs[i].cmd, vecs[i].edges, vecs[i].ack, vecs[i].exp_par,
                    vecs[i].exp_done, vecs[i].exp_code);

        // Randomized sends against the reference outcome model.
        for (int i = 0; i < 6; i++) begin
            b   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            run_vec(b, 11, ack, model_parity(b), ack, ack ? 2'b00 : 2'b11);
        end

        // Extra device clock edges after a completed transfer are ignored.
        d0 = done_cnt; e0 = err_cnt;
        for (int k = 0; k < 2; k++) begin
            dev_clk = 1'b0; repeat (20) @(negedge clk);
            dev_clk = 1'b1; repeat (20) @(negedge clk);
        end
        check("extra_edge_ready", tx_ready, 1);
        check("extra_edge_data_oe", ps2_data_oe, 0);
        check("extra_edge_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        // Reset during edge 4 with tx_valid held high.
        start_tx(PS2_CMD_ENABLE, 1'b1, rel);
        repeat (30) @(negedge clk);
        d0 = done_cnt; e0 = err_cnt;
        dev_clock(3, 1'b1, smp, ff);
        dev_clk = 1'b0;
        repeat (FLT + 6) @(negedge clk);
        check("pre_rst_data_oe", ps2_data_oe, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        @(negedge clk);
        dev_clk = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_accept", ps2_clk_oe, 1);
        check("post_rst_ready", tx_ready, 0);
        check("rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        tx_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
